// File: rtl/pic_pkg.sv
// PIC request/in-service shared definitions.
// INTA FSM encodings, IR count and the rotating priority picker.
package pic_pkg;

    localparam int NUM_IR = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACK1 = 2'd1;
    localparam logic [1:0] ACK2 = 2'd2;

    // Vector returned when INTA arrives with nothing left to serve.
    localparam logic [7:0] SPURIOUS_VEC = 8'h80;

    // One-hot of the highest-priority set bit; rot names the lowest IR,
    // so scanning starts at rot+1 and wraps.
    function automatic logic [7:0] rotate_mask_first(
        input logic [7:0] vec,
        input logic [2:0] rot
    );
        logic [7:0] res;
        logic [2:0] idx;
        logic       found;
        res   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_IR; k++) begin
            idx = rot + 3'd1 + 3'(k);
            if (!found && vec[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// PIC rotating priority resolver.
// Ports: vec (candidate bits), rot (lowest-priority IR) -> onehot (winner or 0).
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] vec,
    input  logic [2:0] rot,
    output logic [7:0] onehot
);

    assign onehot = rotate_mask_first(vec, rot);

endmodule

// File: rtl/interrupt_request_service.sv
// PIC request/in-service datapath: IRR, ISR, INT and the two-pulse INTA sequence.
// Ports: clk, reset_n (sync, active low), irq_in[7:0], int_ack (async, active low),
//   init_clear, level_edge_triggered, int_mask, eoi, priority_rotate, clear_IRR;
//   outputs irr, isr, INT, highest_level_in_service, acknowledge_interrupt, ack_done.
module interrupt_request_service
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] irq_in,
    input  logic       int_ack,
    input  logic       init_clear,
    input  logic       level_edge_triggered,
    input  logic [7:0] int_mask,
    input  logic [7:0] eoi,
    input  logic [2:0] priority_rotate,
    input  logic [7:0] clear_IRR,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic       INT,
    output logic [7:0] highest_level_in_service,
    output logic [7:0] acknowledge_interrupt,
    output logic       ack_done
);

    logic [SYNC_STAGES-1:0][7:0] irq_sync;
    logic [SYNC_STAGES-1:0]      ack_sync;
    logic [7:0]                  irq_d;
    logic                        ack_d;

    logic [7:0] irq_s;
    logic       ack_s;
    logic [7:0] irq_rise;
    logic       ack_fall;
    logic       ack_rise;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] masked_irr;
    logic [7:0] req_vec;
    logic [7:0] set_vec;
    logic [7:0] ack_next;
    logic [7:0] irr_next;
    logic [7:0] isr_next;
    logic       done_next;
    logic       pending;
    logic       int_next;

    // Synchronisers and their edge-detect flops keep running through
    // init_clear; only a real reset empties them.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_sync <= '0;
            ack_sync <= '0;
            irq_d    <= '0;
            ack_d    <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[SYNC_STAGES-2:0], irq_in};
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], int_ack};
            irq_d    <= irq_s;
            ack_d    <= ack_s;
        end
    end

    assign irq_s    = irq_sync[SYNC_STAGES-1];
    assign ack_s    = ack_sync[SYNC_STAGES-1];
    assign irq_rise = irq_s & ~irq_d;
    assign ack_fall = ack_d & ~ack_s;
    assign ack_rise = ~ack_d & ack_s;

    assign masked_irr = irr & ~int_mask;

    pic_priority_resolver u_irr_res (
        .vec    (masked_irr),
        .rot    (priority_rotate),
        .onehot (req_vec)
    );

    pic_priority_resolver u_isr_res (
        .vec    (isr),
        .rot    (priority_rotate),
        .onehot (highest_level_in_service)
    );

    // Fully nested: the request must win outright against the level in
    // service; an equal level (same IR) does not count.
    assign pending = (|req_vec)
        && (rotate_mask_first(req_vec | highest_level_in_service,
                              priority_rotate) == req_vec)
        && (req_vec != highest_level_in_service);

    always_comb begin
        state_next = state;
        set_vec    = '0;
        done_next  = 1'b0;
        ack_next   = acknowledge_interrupt;
        unique case (state)
            IDLE: begin
                if (ack_fall) begin
                    state_next = ACK1;
                    set_vec    = req_vec;
                    ack_next   = (|req_vec) ? req_vec : SPURIOUS_VEC;
                end
            end
            ACK1: begin
                if (ack_fall) begin
                    state_next = ACK2;
                end
            end
            ACK2: begin
                if (ack_rise) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        irr_next = '0;
        if (level_edge_triggered) begin
            irr_next = irq_s & ~clear_IRR;
        end else begin
            irr_next = (irr | irq_rise) & ~clear_IRR & ~set_vec;
        end
    end

    assign isr_next = (isr & ~eoi) | set_vec;

    // INT drops on the edge that starts the sequence, not one later.
    assign int_next = (state == IDLE) && !ack_fall && pending;

    always_ff @(posedge clk) begin
        if (!reset_n || init_clear) begin
            state                 <= IDLE;
            irr                   <= '0;
            isr                   <= '0;
            INT                   <= 1'b0;
            acknowledge_interrupt <= '0;
            ack_done              <= 1'b0;
        end else begin
            state                 <= state_next;
            irr                   <= irr_next;
            isr                   <= isr_next;
            INT                   <= int_next;
            acknowledge_interrupt <= ack_next;
            ack_done              <= done_next;
        end
    end

endmodule

// File: tb/tb_interrupt_request_service.sv
// Bench for interrupt_request_service.
// Directed vectors, rank-based reference model, per-cycle compare.
module tb_interrupt_request_service;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       int_ack;
    logic       init_clear;
    logic       level;
    logic [7:0] mask;
    logic [7:0] eoi;
    logic [2:0] rot;
    logic [7:0] clr;
    logic [7:0] irr;
    logic [7:0] isr;
    logic       INT;
    logic [7:0] hlis;
    logic [7:0] ack;
    logic       ack_done;

    always #5 clk = ~clk;

    interrupt_request_service #(.SYNC_STAGES(S)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .irq_in                   (irq_in),
        .int_ack                  (int_ack),
        .init_clear               (init_clear),
        .level_edge_triggered     (level),
        .int_mask                 (mask),
        .eoi                      (eoi),
        .priority_rotate          (rot),
        .clear_IRR                (clr),
        .irr                      (irr),
        .isr                      (isr),
        .INT                      (INT),
        .highest_level_in_service (hlis),
        .acknowledge_interrupt    (ack),
        .ack_done                 (ack_done)
    );

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic cmp(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Priority rank: 0 = highest, i.e. the IR just after rot.
    function automatic int rank(input int i, input logic [2:0] r);
        return (i - int'(r) - 1 + 16) % 8;
    endfunction

    function automatic logic [7:0] top_of(input logic [7:0] v,
                                          input logic [2:0] r);
        int best;
        logic [7:0] res;
        best = -1;
        res  = '0;
        for (int i = 0; i < 8; i++)
            if (v[i] && (best < 0 || rank(i, r) < rank(best, r))) best = i;
        if (best >= 0) res[best] = 1'b1;
        return res;
    endfunction

    function automatic bit outranks(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] r);
        if (a == 0) return 1'b0;
        if (b == 0) return 1'b1;
        return rank($clog2(a), r) < rank($clog2(b), r);
    endfunction

    // Reference model, advanced once per rising edge.
    logic [7:0] m_irr, m_isr, m_ack;
    logic       m_int, m_done;
    int         m_phase;
    logic [7:0] irq_hist[$];
    logic       ack_hist[$];

    always @(posedge clk) begin
        logic [7:0] i_s, i_p, req, hl, set;
        logic       a_s, a_p, fall, rise, nint;
        int         old_phase;
        if (!reset_n) begin
            m_irr = 0; m_isr = 0; m_ack = 0; m_int = 0; m_done = 0;
            m_phase = 0;
            irq_hist.delete();
            ack_hist.delete();
            for (int i = 0; i <= S; i++) begin
                irq_hist.push_back(8'h00);
                ack_hist.push_back(1'b0);
            end
        end else begin
            // hist[k] = sample taken k+1 edges ago
            i_s = irq_hist[S-1];
            i_p = irq_hist[S];
            a_s = ack_hist[S-1];
            a_p = ack_hist[S];
            fall = a_p && !a_s;
            rise = !a_p && a_s;
            if (init_clear) begin
                m_irr = 0; m_isr = 0; m_ack = 0; m_int = 0; m_done = 0;
                m_phase = 0;
            end else begin
                req = top_of(m_irr & ~mask, rot);
                hl  = top_of(m_isr, rot);
                old_phase = m_phase;
                set = 0;
                m_done = 0;
                if (m_phase == 0 && fall) begin
                    m_phase = 1;
                    set = req;
                    m_ack = (req != 0) ? req : 8'h80;
                end else if (m_phase == 1 && fall) begin
                    m_phase = 2;
                end else if (m_phase == 2 && rise) begin
                    m_phase = 0;
                    m_done = 1;
                end
                nint = (old_phase == 0) && !fall && outranks(req, hl, rot);
                if (level) m_irr = i_s & ~clr;
                else m_irr = (m_irr | (i_s & ~i_p)) & ~clr & ~set;
                m_isr = (m_isr & ~eoi) | set;
                m_int = nint;
            end
            irq_hist.push_front(irq_in);
            void'(irq_hist.pop_back());
            ack_hist.push_front(int_ack);
            void'(ack_hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("cyc_irr", irr, m_irr);
            cmp("cyc_isr", isr, m_isr);
            cmp("cyc_int", {7'b0, INT}, {7'b0, m_int});
            cmp("cyc_hlis", hlis, top_of(m_isr, rot));
            cmp("cyc_ack", ack, m_ack);
            cmp("cyc_done", {7'b0, ack_done}, {7'b0, m_done});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Full two-pulse INTA; reports whether ack_done was seen in time.
    task automatic inta_seq(output bit seen);
        seen = 1'b0;
        int_ack = 1'b0; tick(4);
        int_ack = 1'b1; tick(4);
        int_ack = 1'b0; tick(4);
        int_ack = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (ack_done) seen = 1'b1;
            #1;
        end
        tick(2);
    endtask

    bit seen;
    logic [7:0] e;

    initial begin
        reset_n = 0; irq_in = 0; int_ack = 1; init_clear = 0; level = 0;
        mask = 0; eoi = 0; rot = 3'b111; clr = 0;
        tick(3);
        cmp_en = 1'b1;
        cmp("rst_irr", irr, 8'h00);
        cmp("rst_isr", isr, 8'h00);
        cmp("rst_int", {7'b0, INT}, 8'h00);
        cmp("rst_ack", ack, 8'h00);
        reset_n = 1;
        tick(4);

        // basic edge request and acknowledge
        irq_in = 8'h08;
        tick(3);
        cmp("t1_irr", irr, 8'h08);
        tick(1);
        cmp("t1_int", {7'b0, INT}, 8'h01);
        inta_seq(seen);
        cmp("t1_done", {7'b0, seen}, 8'h01);
        cmp("t1_isr", isr, 8'h08);
        cmp("t1_irr_clr", irr, 8'h00);
        cmp("t1_ack", ack, 8'h08);

        // fully nested
        irq_in = 8'h28;
        tick(5);
        cmp("t2_irr", irr, 8'h20);
        cmp("t2_int_low", {7'b0, INT}, 8'h00);
        irq_in = 8'h2A;
        tick(4);
        cmp("t2_int_ir1", {7'b0, INT}, 8'h01);
        inta_seq(seen);
        cmp("t2_isr", isr, 8'h0A);
        cmp("t2_hlis", hlis, 8'h02);
        cmp("t2_ack", ack, 8'h02);
        eoi = 8'h0A; tick(1); eoi = 0;
        clr = 8'h20; tick(1); clr = 0;
        irq_in = 0;
        tick(4);

        // rotation
        rot = 3'd4;
        irq_in = 8'h21;
        tick(4);
        cmp("t3_irr", irr, 8'h21);
        inta_seq(seen);
        cmp("t3_ack", ack, 8'h20);
        cmp("t3_isr", isr, 8'h20);
        cmp("t3_irr_left", irr, 8'h01);
        eoi = 8'h20; tick(1); eoi = 0;
        tick(2);
        cmp("t3_int_ir0", {7'b0, INT}, 8'h01);
        inta_seq(seen);
        cmp("t3_ack_ir0", ack, 8'h01);
        eoi = 8'h01; tick(1); eoi = 0;
        irq_in = 0; rot = 3'b111;
        tick(4);

        // spurious in level mode
        level = 1;
        irq_in = 8'h10;
        tick(4);
        cmp("t4_irr", irr, 8'h10);
        cmp("t4_int", {7'b0, INT}, 8'h01);
        irq_in = 0;
        tick(3);
        inta_seq(seen);
        cmp("t4_ack_spur", ack, 8'h80);
        cmp("t4_isr", isr, 8'h00);
        cmp("t4_done", {7'b0, seen}, 8'h01);

        // masking and eoi racing an ISR set
        level = 0;
        mask = 8'h08;
        irq_in = 8'h08;
        tick(5);
        cmp("t5_irr", irr, 8'h08);
        cmp("t5_int_masked", {7'b0, INT}, 8'h00);
        mask = 0;
        tick(1);
        cmp("t5_int_unmask", {7'b0, INT}, 8'h01);
        int_ack = 0; tick(2);
        eoi = 8'h08; tick(1); eoi = 0;
        cmp("t5_isr_setwins", isr, 8'h08);
        cmp("t5_ack", ack, 8'h08);
        tick(1);
        int_ack = 1; tick(4);
        int_ack = 0; tick(4);
        int_ack = 1; tick(6);
        eoi = 8'h08; tick(1); eoi = 0;

        // reset inside ACK1
        irq_in = 0; tick(3);
        irq_in = 8'h08; tick(4);
        cmp("t6_int", {7'b0, INT}, 8'h01);
        int_ack = 0; tick(4);
        cmp("t6_isr_ack1", isr, 8'h08);
        reset_n = 0; tick(1);
        cmp("t6_irr", irr, 8'h00);
        cmp("t6_isr", isr, 8'h00);
        cmp("t6_int0", {7'b0, INT}, 8'h00);
        cmp("t6_nodone", {7'b0, ack_done}, 8'h00);
        reset_n = 1; int_ack = 1;
        tick(8);
        inta_seq(seen);
        cmp("t6_idle_seq", {7'b0, seen}, 8'h01);
        cmp("t6_ack", ack, 8'h08);

        // fill ISR by rotating, then init_clear
        eoi = 8'h08; tick(1); eoi = 0;
        irq_in = 0; level = 1;
        tick(2);
        irq_in = 8'hFF;
        tick(4);
        for (int k = 0; k < 8; k++) begin
            rot = 3'(k + 7);
            e = 8'h01 << k;
            inta_seq(seen);
            cmp("ff_ack", ack, e);
        end
        cmp("ff_isr", isr, 8'hFF);
        init_clear = 1; tick(1); init_clear = 0;
        cmp("init_isr", isr, 8'h00);
        cmp("init_irr", irr, 8'h00);
        cmp("init_int", {7'b0, INT}, 8'h00);
        cmp("init_ack", ack, 8'h00);
        tick(4);

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
